// File: rtl/maze_grid_if.sv
// Packet input, renderer read port and status signals of maze_grid_ctrl.
// The bench drives the master side and the controller implements the slave side.
interface maze_grid_if #(
    parameter int DROP_W = 8
);
    logic [15:0]       pkt_in;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [1:0]        rd_x;
    logic [2:0]        rd_y;
    logic [2:0]        rd_type;
    logic [3:0]        rd_walls;
    logic [1:0]        cur_x;
    logic [2:0]        cur_y;
    logic              cur_valid;
    logic              busy;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output pkt_in, pkt_valid, rd_x, rd_y,
        input  pkt_ready, rd_type, rd_walls, cur_x, cur_y, cur_valid, busy, drop_count
    );

    modport slave (
        input  pkt_in, pkt_valid, rd_x, rd_y,
        output pkt_ready, rd_type, rd_walls, cur_x, cur_y, cur_valid, busy, drop_count
    );
endinterface

// File: rtl/maze_grid_ctrl.sv
// 4x5 maze map built from robot packets through a small FIFO, with a registered renderer read port.
// Define MAZE_GRID_WALLS_EN to build wall storage and OR-merging; without it RD_WALLS reads 0000.
module maze_grid_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    maze_grid_if.slave  bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CELLS = 20;

    typedef enum logic [2:0] {CLEAR, IDLE, DECODE, WRITE, DEMOTE} state_t;
    state_t state_reg, state_next;

    logic [11:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              ready_en_reg;
    logic              full, push, pop;

    logic [11:0]       pkt_reg;
    logic [4:0]        clr_idx_reg;
    logic [1:0]        cur_x_reg;
    logic [2:0]        cur_y_reg;
    logic              cur_valid_reg;
    logic [4:0]        demote_idx_reg;
    logic [DROP_W-1:0] drop_reg;
    logic [2:0]        rd_type_reg;
    logic [2:0]        type_mem [CELLS];

    logic              cell_we, decode_drop, load_cur;
    logic [4:0]        w_idx;
    logic [2:0]        w_type;

    // Packet register holds PKT_IN[15:4]: {x, y, type, walls}
    wire [1:0] pkt_x     = pkt_reg[11:10];
    wire [2:0] pkt_y     = pkt_reg[9:7];
    wire [2:0] pkt_type  = pkt_reg[6:4];
    wire [3:0] pkt_walls = pkt_reg[3:0];
    wire [4:0] pkt_idx   = {pkt_y, pkt_x};
    wire [4:0] cur_idx   = {cur_y_reg, cur_x_reg};
    wire [4:0] rd_idx    = {bus.rd_y, bus.rd_x};

    assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign push  = bus.pkt_valid && bus.pkt_ready;
    wire in_drop = bus.pkt_valid && !bus.pkt_ready;

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        cell_we     = 1'b0;
        decode_drop = 1'b0;
        load_cur    = 1'b0;
        w_idx       = clr_idx_reg;
        w_type      = 3'b000;
        case (state_reg)
            CLEAR: begin
                cell_we = 1'b1;
                if (clr_idx_reg == 5'd19) state_next = IDLE;
            end
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (pkt_y > 3'd4 || pkt_type == 3'b111) begin
                    decode_drop = 1'b1;
                    state_next  = IDLE;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                cell_we    = 1'b1;
                w_idx      = pkt_idx;
                w_type     = pkt_type;
                state_next = IDLE;
                if (pkt_type == 3'b110) begin
                    load_cur = 1'b1;
                    if (cur_valid_reg && cur_idx != pkt_idx) state_next = DEMOTE;
                end
            end
            DEMOTE: begin
                cell_we    = 1'b1;
                w_idx      = demote_idx_reg;
                w_type     = 3'b001;
                state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= CLEAR;
        else     state_reg <= state_next;
    end

    wire [1:0]        drop_inc = {1'b0, in_drop} + {1'b0, decode_drop};
    wire [DROP_W:0]   drop_sum = {1'b0, drop_reg} + (DROP_W+1)'(drop_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ready_en_reg   <= 1'b0;
            pkt_reg        <= '0;
            clr_idx_reg    <= '0;
            cur_x_reg      <= '0;
            cur_y_reg      <= '0;
            cur_valid_reg  <= 1'b0;
            demote_idx_reg <= '0;
            drop_reg       <= '0;
            rd_type_reg    <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                pkt_reg    <= fifo_mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            clr_idx_reg <= (state_reg == CLEAR) ? clr_idx_reg + 5'd1 : 5'd0;
            if (load_cur) begin
                demote_idx_reg <= cur_idx;
                cur_x_reg      <= pkt_x;
                cur_y_reg      <= pkt_y;
                cur_valid_reg  <= 1'b1;
            end
            drop_reg    <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            rd_type_reg <= (bus.rd_y > 3'd4) ? 3'b000 : type_mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push)    fifo_mem[wr_ptr_reg] <= bus.pkt_in[15:4];
        if (cell_we) type_mem[w_idx]      <= w_type;
    end

`ifdef MAZE_GRID_WALLS_EN
    logic [3:0] walls_mem [CELLS];
    logic [3:0] rd_walls_reg;

    // Walls only accumulate; DEMOTE leaves them untouched
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR)      walls_mem[clr_idx_reg] <= 4'b0000;
        else if (state_reg == WRITE) walls_mem[pkt_idx]     <= walls_mem[pkt_idx] | pkt_walls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_walls_reg <= '0;
        else     rd_walls_reg <= (bus.rd_y > 3'd4) ? 4'b0000 : walls_mem[rd_idx];
    end

    assign bus.rd_walls = rd_walls_reg;
    wire unused_bits = ^bus.pkt_in[3:0];
`else
    assign bus.rd_walls = 4'b0000;
    wire unused_bits = ^{bus.pkt_in[3:0], pkt_walls};
`endif

    assign bus.pkt_ready  = ready_en_reg && !full;
    assign bus.rd_type    = rd_type_reg;
    assign bus.cur_x      = cur_x_reg;
    assign bus.cur_y      = cur_y_reg;
    assign bus.cur_valid  = cur_valid_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.drop_count = drop_reg;
endmodule

// File: tb/tb_maze_grid_ctrl.sv
// Scoreboard bench for maze_grid_ctrl: a cell-map model predicts reads, results are queued and checked.
module tb_maze_grid_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_W     = 8;
`ifdef MAZE_GRID_WALLS_EN
    localparam bit WALLS = 1'b1;
`else
    localparam bit WALLS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    maze_grid_if #(.DROP_W(DROP_W)) bus ();

    maze_grid_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] m_type  [20];
    logic [3:0] m_walls [20];
    logic [1:0] m_cx;
    logic [2:0] m_cy;
    logic       m_cv;
    int         m_drop;
    logic [6:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 20; i++) begin
            m_type[i]  = 3'b000;
            m_walls[i] = 4'b0000;
        end
        m_cx = 2'd0; m_cy = 3'd0; m_cv = 1'b0; m_drop = 0;
    endtask

    task automatic model_drop();
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
    endtask

    task automatic model_apply(input logic [1:0] x, input logic [2:0] y,
                               input logic [2:0] t, input logic [3:0] w);
        int idx;
        if (y > 3'd4 || t == 3'b111) begin
            model_drop();
        end else begin
            idx = int'(y) * 4 + int'(x);
            m_type[idx]  = t;
            m_walls[idx] = m_walls[idx] | w;
            if (t == 3'b110) begin
                if (m_cv && (m_cx != x || m_cy != y)) m_type[int'(m_cy) * 4 + int'(m_cx)] = 3'b001;
                m_cx = x; m_cy = y; m_cv = 1'b1;
            end
        end
    endtask

    task automatic drive_pkt(input logic [1:0] x, input logic [2:0] y, input logic [2:0] t,
                             input logic [3:0] w, input logic exp_acc);
        bus.pkt_in    = {x, y, t, w, 4'h5};
        bus.pkt_valid = 1'b1;
        check("pkt_ready", bus.pkt_ready, exp_acc);
        step();
        bus.pkt_valid = 1'b0;
        $display("pkt x=%0d y=%0d type=%b walls=%b accept=%0d", x, y, t, w, exp_acc);
        if (exp_acc) model_apply(x, y, t, w);
        else         model_drop();
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.busy) n++;
        end
    endtask

    task automatic read_cell(input logic [1:0] x, input logic [2:0] y);
        logic [6:0] e;
        int idx;
        bus.rd_x = x;
        bus.rd_y = y;
        if (y > 3'd4) begin
            e = 7'd0;
        end else begin
            idx = int'(y) * 4 + int'(x);
            e = {m_type[idx], WALLS ? m_walls[idx] : 4'b0000};
        end
        exp_q.push_back(e);
        step();
        e = exp_q.pop_front();
        $display("read x=%0d y=%0d type=%b walls=%b", x, y, bus.rd_type, bus.rd_walls);
        check($sformatf("rd_type(%0d,%0d)", x, y), bus.rd_type, e[6:4]);
        check($sformatf("rd_walls(%0d,%0d)", x, y), bus.rd_walls, e[3:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.pkt_ready, 0);
        check({tag, "_rd_type"}, bus.rd_type, 0);
        check({tag, "_rd_walls"}, bus.rd_walls, 0);
        check({tag, "_cur_x"}, bus.cur_x, 0);
        check({tag, "_cur_y"}, bus.cur_y, 0);
        check({tag, "_cur_valid"}, bus.cur_valid, 0);
        check({tag, "_drop"}, bus.drop_count, 0);
        check({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic release_and_clear(input string tag);
        int n;
        rst = 1'b0;
        check({tag, "_ready_low"}, bus.pkt_ready, 0);
        n = 0;
        step();
        n++;
        check({tag, "_ready_rise"}, bus.pkt_ready, 1);
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        check({tag, "_clear_cycles"}, n, 20);
    endtask

    logic [1:0] qx [6] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2};
    logic [2:0] qy [6] = '{3'd1, 3'd1, 3'd4, 3'd1, 3'd0, 3'd0};
    logic [2:0] qt [6] = '{3'd2, 3'd3, 3'd6, 3'd6, 3'd4, 3'd5};
    logic [3:0] qw [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b1111, 4'b1111};

    initial begin
        int n;
        bus.pkt_in = '0; bus.pkt_valid = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
        model_reset();

        #1 rst = 1'b1;
        #2 check_reset_outputs("por");
        step();
        step();
        release_and_clear("por");

        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 4; x++) read_cell(2'(x), 3'(y));

        // Exact write edge: a same-cycle read still sees the old cell
        bus.rd_x = 2'd2; bus.rd_y = 3'd3;
        bus.pkt_in = {2'd2, 3'd3, 3'b001, 4'b0001, 4'h0};
        bus.pkt_valid = 1'b1;
        check("lat_ready_c0", bus.pkt_ready, 1);
        step();
        bus.pkt_valid = 1'b0;
        check("lat_busy_c1", bus.busy, 0);
        step();
        check("lat_busy_c2", bus.busy, 1);
        step();
        step();
        check("lat_rd_same_cycle", bus.rd_type, 0);
        step();
        check("lat_rd_after", bus.rd_type, 1);
        model_apply(2'd2, 3'd3, 3'b001, 4'b0001);
        read_cell(2'd2, 3'd3);

        drive_pkt(2'd2, 3'd3, 3'b001, 4'b0100, 1'b1);
        busy_cycles(n);
        read_cell(2'd2, 3'd3);

        drive_pkt(2'd0, 3'd0, 3'b110, 4'b0010, 1'b1);
        busy_cycles(n);
        check("first_cur_busy", n, 2);
        drive_pkt(2'd1, 3'd4, 3'b110, 4'b0000, 1'b1);
        busy_cycles(n);
        check("demote_busy", n, 3);
        read_cell(2'd0, 3'd0);
        read_cell(2'd1, 3'd4);
        check("cur_x", bus.cur_x, 1);
        check("cur_y", bus.cur_y, 4);
        check("cur_valid", bus.cur_valid, 1);
        drive_pkt(2'd1, 3'd4, 3'b110, 4'b0001, 1'b1);
        busy_cycles(n);
        check("repeat_no_demote_busy", n, 2);
        read_cell(2'd1, 3'd4);

        drive_pkt(2'd3, 3'd5, 3'b001, 4'b1111, 1'b1);
        busy_cycles(n);
        drive_pkt(2'd0, 3'd0, 3'b111, 4'b1111, 1'b1);
        busy_cycles(n);
        check("drop_count", bus.drop_count, 32'(m_drop));
        read_cell(2'd0, 3'd0);
        read_cell(2'd3, 3'd1);

        // Reset lands while the old current cell is being demoted
        drive_pkt(2'd2, 3'd2, 3'b110, 4'b0001, 1'b1);
        step();
        step();
        step();
        check("in_demote_busy", bus.busy, 1);
        rst = 1'b1;
        #2 check_reset_outputs("mid");
        step();
        model_reset();
        release_and_clear("mid_pre");
        read_cell(2'd2, 3'd2);
        read_cell(2'd1, 3'd4);

        // Back-to-back packets during a fresh clear sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("clr_ready_low", bus.pkt_ready, 0);
        step();
        for (int i = 0; i < FIFO_DEPTH + 2; i++)
            drive_pkt(qx[i], qy[i], qt[i], qw[i], i < FIFO_DEPTH);
        check("clr_busy", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        for (int i = 0; i < 30; i++) step();
        for (int i = 0; i < FIFO_DEPTH + 2; i++) read_cell(qx[i], qy[i]);
        read_cell(2'd2, 3'd2);
        check("clr_cur_x", bus.cur_x, 32'(m_cx));
        check("clr_cur_y", bus.cur_y, 32'(m_cy));
        check("clr_cur_valid", bus.cur_valid, 32'(m_cv));
        check("clr_drop_count", bus.drop_count, 32'(m_drop));
        check("clr_idle_ready", bus.pkt_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/maze_grid_ctrl.md
MAZE_GRID_CTRL -- requirements
Module: maze_grid_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: packet FIFO entries, power of two, 2..16.
REQ-002 Parameter DROP_W, default 8: width of DROP_COUNT.
REQ-003 CLOCK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 PKT_IN  in  16  robot packet: [15:14] x, [13:11] y, [10:8] type, [7:4] walls (bit4 N, bit5 E, bit6 S, bit7 W), [3:0] ignored.
REQ-006 PKT_VALID  in  1  PKT_IN qualifier, one packet per high cycle.
REQ-007 PKT_READY  out  1  FIFO not full.
REQ-008 RD_X  in  2 / RD_Y  in  3  renderer read address.
REQ-009 RD_TYPE  out  3 / RD_WALLS  out  4  registered cell contents at the read address.
REQ-010 CUR_X  out  2 / CUR_Y  out  3 / CUR_VALID  out  1  last cell written with type 110 (current).
REQ-011 BUSY  out  1  high in CLEAR, DECODE, WRITE, DEMOTE.
REQ-012 DROP_COUNT  out  DROP_W  saturating count of rejected packets.

Function
REQ-013 The block SHALL hold a 4x5 cell array, each cell 3-bit type and 4-bit walls.
REQ-014 A packet SHALL be pushed when PKT_VALID and PKT_READY are both high; PKT_VALID with PKT_READY low SHALL drop the packet and increment DROP_COUNT.
REQ-015 FSM states: CLEAR, IDLE, DECODE, WRITE, DEMOTE.
REQ-016 CLEAR SHALL write type 000 and walls 0000 to one cell per cycle, index y*4+x from 0 to 19, then go to IDLE (20 cycles).
REQ-017 IDLE with the FIFO non-empty SHALL pop the head into the packet register and go to DECODE.
REQ-018 DECODE SHALL drop the packet (DROP_COUNT+1, return to IDLE) if y>4 or type==111; otherwise it SHALL go to WRITE.
REQ-019 WRITE SHALL overwrite the cell type and OR packet walls into the stored walls (walls never clear except in CLEAR).
REQ-020 WRITE with type 110, CUR_VALID high, and (CUR_X,CUR_Y) different from the packet cell SHALL go to DEMOTE; all other cases SHALL return to IDLE.
REQ-021 DEMOTE SHALL set the old current cell type to 001 (visited), leaving its walls unchanged, then return to IDLE.
REQ-022 Any WRITE with type 110 SHALL load CUR_X/CUR_Y from the packet and set CUR_VALID on that same edge.
REQ-023 Latency: with the FSM idle and the FIFO empty, a packet accepted in cycle 0 SHALL be written to the array at the edge ending cycle 3.
REQ-024 RD_TYPE/RD_WALLS SHALL be valid one cycle after RD_X/RD_Y; RD_Y>4 SHALL return 000/0000; a same-cycle write returns the old value.
REQ-025 FIFO push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-026 The FIFO SHALL accept packets during CLEAR; they are processed after CLEAR completes.
REQ-027 DROP_COUNT SHALL saturate at all-ones.

Reset
REQ-028 RESET SHALL asynchronously force state CLEAR with clear index 0, FIFO empty, PKT_READY 0, RD_TYPE 000, RD_WALLS 0000, CUR_X 0, CUR_Y 0, CUR_VALID 0, DROP_COUNT 0, BUSY 1.
REQ-029 PKT_READY SHALL rise one cycle after RESET deasserts.
REQ-030 RESET asserted mid-operation SHALL discard all FIFO contents and any in-flight packet, then restart the full clear sweep.

Configuration
REQ-031 Macro MAZE_GRID_WALLS_EN defined: wall storage, wall OR-merge, and RD_WALLS operate as specified.
REQ-032 Macro MAZE_GRID_WALLS_EN undefined: no wall storage is built, RD_WALLS is constant 0000, and PKT_IN[7:4] is ignored; all other behaviour is unchanged.

Verification
REQ-033 Reset released, no packets -> BUSY high 20 cycles; afterwards every RD address reads 000/0000.
REQ-034 Packet x=2,y=3,type=001,walls=0001 at cycle 0 -> array written at end of cycle 3; RD_X=2,RD_Y=3 reads 001/0001; second packet with walls=0100 -> reads 0101.
REQ-035 Type 110 packet to (0,0), then type 110 packet to (1,4) -> (0,0) reads 001, (1,4) reads 110, CUR_X=1, CUR_Y=4; repeating (1,4) -> no DEMOTE.
REQ-036 Packets with y=5 and with type=111 -> array unchanged, DROP_COUNT=2.
REQ-037 FIFO_DEPTH+2 back-to-back PKT_VALID during CLEAR -> PKT_READY low once full, extra packets dropped and counted, queued packets applied in order after CLEAR.
REQ-038 RESET pulse during a DEMOTE -> all outputs at reset values, FIFO empty, clear sweep restarts; with MAZE_GRID_WALLS_EN undefined, REQ-034 reads walls 0000.
